tinygrev_arbiter: RTL and testbench

- Shares one multi-cycle tinygrev unit between NREQ independent requesters.
- Each requester has a valid/ready request channel (rs1, rs2) and a valid/ready response channel (rd, err).
- The block round-robin arbitrates requests, drives the unit's start/rs1/rs2, waits for done, and routes the captured rd back to the granted requester.
- A watchdog bounds every operation. A post-reset flush keeps a stale in-flight operation from being mistaken for a new result.

---
 rtl/tinygrev_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_tinygrev_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinygrev_arbiter.sv
// -----------------------------------------------------------------------------
// tinygrev_arbiter
//   Shares one multi-cycle tinygrev unit between NREQ requesters. Requests are
//   picked round-robin in IDLE, issued to the unit with a one-cycle start
//   pulse, and the unit result (or a watchdog timeout) is returned on the
//   granted requester's response channel. After reset, and after a timeout,
//   the block sits in FLUSH for TIMEOUT cycles so a late grev_done from an
//   abandoned operation can never be taken as a fresh result.
//
// Ports
//   clock, resetn       clock; synchronous active-low reset
//   req_valid/ready     per-requester request handshake (ready one-hot or 0)
//   req_rs1, req_rs2    packed operands: requester i at [32*i+:32] / [5*i+:5]
//   rsp_valid/ready     per-requester response handshake (valid one-hot or 0)
//   rsp_rd, rsp_err     shared result; err=1 means timed out and rd=0
//   grev_start          one-cycle start pulse to the unit
//   grev_rs1, grev_rs2  operands to the unit, stable from start until done
//   grev_rd, grev_done  unit result and completion strobe
//   busy                1 in every state except IDLE
// -----------------------------------------------------------------------------
module tinygrev_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_rs1,
  input  logic [NREQ*5-1:0]    req_rs2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_rd,
  output logic                 rsp_err,
  output logic                 grev_start,
  output logic [31:0]          grev_rs1,
  output logic [4:0]           grev_rs2,
  input  logic [31:0]          grev_rd,
  input  logic                 grev_done,
  output logic                 busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef logic [GW-1:0] idx_t;
  typedef logic [GW:0]   sum_t;
  typedef logic [CW-1:0] cnt_t;

  localparam sum_t NREQ_W   = sum_t'(NREQ);
  localparam idx_t LAST_IDX = idx_t'(NREQ - 1);
  localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  cnt_t        r_cnt;
  idx_t        r_ptr;
  idx_t        r_grant;
  logic        r_start;
  logic [31:0] r_rs1;
  logic [4:0]  r_rs2;
  logic [31:0] r_rd;
  logic        r_err;

  state_t      w_next_state;
  logic        w_found;
  idx_t        w_pick;
  sum_t        w_sum;
  logic [31:0] w_pick_rs1;
  logic [4:0]  w_pick_rs2;
  logic        w_accept;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_cap_done;
  logic        w_cap_tmo;
  logic        w_rsp_hs;

  // Round-robin pick: first valid requester at or after r_ptr, wrapping.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_sum      = '0;
    w_pick_rs1 = '0;
    w_pick_rs2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + sum_t'(k);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (!w_found && req_valid[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[GW-1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == idx_t'(i)) begin
        w_pick_rs1 = req_rs1[32*i +: 32];
        w_pick_rs2 = req_rs2[5*i +: 5];
      end
    end
  end

  // Handshake outputs decode from state. req_ready is also gated by resetn so
  // a request coinciding with reset is visibly not accepted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = resetn && (r_state == S_IDLE) && w_found && (w_pick == idx_t'(i));
      rsp_valid[i] = (r_state == S_RESP) && (r_grant == idx_t'(i));
    end
  end

  assign w_rsp_hs = rsp_ready[r_grant];

  // Next-state and datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cap_done   = 1'b0;
    w_cap_tmo    = 1'b0;
    case (r_state)
      S_FLUSH: begin
        // grev_done is deliberately ignored while draining.
        if (r_cnt == CNT_LAST) begin
          w_next_state = S_IDLE;
          w_cnt_clr    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_IDLE: begin
        if (w_found) begin
          w_accept     = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next_state = S_WAIT;
        w_cnt_clr    = 1'b1;
      end
      S_WAIT: begin
        // A completion in the last watchdog cycle still counts as success.
        if (grev_done) begin
          w_cap_done   = 1'b1;
          w_next_state = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_cap_tmo    = 1'b1;
          w_next_state = S_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          // After a timeout the unit may still finish; drain it first.
          w_next_state = r_err ? S_FLUSH : S_IDLE;
          w_cnt_clr    = r_err;
        end
      end
      default: begin
        w_next_state = S_FLUSH;
        w_cnt_clr    = 1'b1;
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_FLUSH;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_start <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

      // High only in the ISSUE cycle that follows an accept.
      r_start <= w_accept;

      if (w_accept) begin
        r_grant <= w_pick;
        r_rs1   <= w_pick_rs1;
        r_rs2   <= w_pick_rs2;
        r_ptr   <= (w_pick == LAST_IDX) ? '0 : w_pick + 1'b1;
      end

      if (w_cap_done) begin
        r_rd  <= grev_rd;
        r_err <= 1'b0;
      end else if (w_cap_tmo) begin
        r_rd  <= '0;
        r_err <= 1'b1;
      end
    end
  end

  assign grev_start = r_start;
  assign grev_rs1   = r_rs1;
  assign grev_rs2   = r_rs2;
  assign rsp_rd     = r_rd;
  assign rsp_err    = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_tinygrev_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tinygrev_arbiter
//   Directed sequence (contention, single request, backpressure, timeout,
//   reset mid-WAIT) followed by a random phase. A behavioural tinygrev unit
//   answers start pulses after a programmable latency; a scoreboard queue
//   holds the expected response of every accepted request.
// -----------------------------------------------------------------------------
module tb_tinygrev_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [31:0] rs1;
    logic [4:0]  rs2;
  } op_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic                 clock;
  logic                 resetn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_rs1;
  logic [NREQ*5-1:0]    req_rs2;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_rd;
  logic                 rsp_err;
  logic                 grev_start;
  logic [31:0]          grev_rs1;
  logic [4:0]           grev_rs2;
  logic [31:0]          grev_rd;
  logic                 grev_done;
  logic                 busy;

  tinygrev_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err),
    .grev_start (grev_start),
    .grev_rs1   (grev_rs1),
    .grev_rs2   (grev_rs2),
    .grev_rd    (grev_rd),
    .grev_done  (grev_done),
    .busy       (busy)
  );

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  // Stimulus / scoreboard state; each variable has a single writing process.
  op_t        stim_q [NREQ][$];   // main
  int         rd_ptr [NREQ];      // driver
  int         hs_seen[NREQ];      // driver
  int         gap    [NREQ];      // driver
  int         hs_cnt [NREQ];      // monitor
  exp_t       sb_q[$];            // monitor
  logic [7:0] grant_log[$];       // monitor
  int         rsp_hs_cnt = 0;     // monitor
  bit         hold   [NREQ];      // main
  bit         rand_gaps  = 0;     // main
  bit         rand_stall = 0;     // main
  bit         unit_mute  = 0;     // main
  int         unit_lat   = 5;     // main

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] ref_grev(input logic [31:0] x, input logic [4:0] k);
    logic [31:0] y;
    y = x;
    if (k[0]) y = ((y & 32'h5555_5555) << 1) | ((y & 32'hAAAA_AAAA) >> 1);
    if (k[1]) y = ((y & 32'h3333_3333) << 2) | ((y & 32'hCCCC_CCCC) >> 2);
    if (k[2]) y = ((y & 32'h0F0F_0F0F) << 4) | ((y & 32'hF0F0_F0F0) >> 4);
    if (k[3]) y = ((y & 32'h00FF_00FF) << 8) | ((y & 32'hFF00_FF00) >> 8);
    if (k[4]) y = (y << 16) | (y >> 16);
    return y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural tinygrev unit: done pulses unit_lat cycles after start, with
  // the reference result; grev_rd carries junk on every other cycle.
  // ---------------------------------------------------------------------------
  initial begin
    int          remain;
    logic [31:0] u_rs1;
    logic [4:0]  u_rs2;
    remain    = 0;
    u_rs1     = '0;
    u_rs2     = '0;
    grev_done = 1'b0;
    grev_rd   = '0;
    forever begin
      @(posedge clock); #1;
      grev_done = 1'b0;
      grev_rd   = $urandom;
      if (remain > 0) begin
        remain--;
        if (remain == 0 && !unit_mute) begin
          grev_done = 1'b1;
          grev_rd   = ref_grev(u_rs1, u_rs2);
        end
      end
      if (grev_start) begin
        u_rs1  = grev_rs1;
        u_rs2  = grev_rs2;
        remain = unit_lat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requester driver: presents queued ops in order, drops valid after each
  // accept, optional random gaps and response stalls.
  // ---------------------------------------------------------------------------
  initial begin
    req_valid = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd_ptr[i]  = 0;
      hs_seen[i] = 0;
      gap[i]     = 0;
    end
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_cnt[i] != hs_seen[i]) begin
          hs_seen[i]   = hs_cnt[i];
          rd_ptr[i]    = rd_ptr[i] + 1;
          req_valid[i] = 1'b0;
          gap[i]       = rand_gaps ? int'($urandom_range(0, 4)) : 0;
        end
        if (!req_valid[i] && rd_ptr[i] < stim_q[i].size()) begin
          if (gap[i] > 0) begin
            gap[i]--;
          end else begin
            req_valid[i]        = 1'b1;
            req_rs1[32*i +: 32] = stim_q[i][rd_ptr[i]].rs1;
            req_rs2[5*i +: 5]   = stim_q[i][rd_ptr[i]].rs2;
          end
        end
        rsp_ready[i] = hold[i] ? 1'b0 : (rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard, sampled on the falling edge.
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] prev_valid = '0;
  logic [31:0]     prev_rd    = '0;
  logic            prev_hs    = 1'b0;
  logic            prev_start = 1'b0;
  int              start_cyc  = 0;
  int              done_cyc   = 0;
  logic [31:0]     cap_rs1    = '0;
  logic [4:0]      cap_rs2    = '0;
  bit              op_live    = 0;
  exp_t            mon_e;

  always @(negedge clock) begin
    if (!resetn) begin
      sb_q.delete();
      op_live    = 0;
      prev_valid = '0;
      prev_hs    = 1'b0;
      prev_start = 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_cnt[i]++;
          mon_e.idx = 8'(i);
          mon_e.rd  = unit_mute ? 32'h0 : ref_grev(req_rs1[32*i +: 32], req_rs2[5*i +: 5]);
          mon_e.err = unit_mute;
          sb_q.push_back(mon_e);
          grant_log.push_back(8'(i));
        end
      end

      if (busy) check("req_ready_while_busy", 32'(req_ready), 32'h0);
      if (prev_start) check("start_width", 32'(grev_start), 32'h0);

      if (grev_start) begin
        start_cyc = cyc;
        cap_rs1   = grev_rs1;
        cap_rs2   = grev_rs2;
        op_live   = 1;
      end
      if (grev_done && op_live) begin
        done_cyc = cyc;
        op_live  = 0;
        check("rs1_hold", grev_rs1, cap_rs1);
        check("rs2_hold", 32'(grev_rs2), 32'(cap_rs2));
      end

      if (rsp_valid != '0) begin
        check("rsp_onehot", 32'($onehot(rsp_valid)), 32'h1);
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          mon_e = sb_q[0];
          check("rsp_route", 32'(rsp_valid), 32'h1 << mon_e.idx);
          check("rsp_rd", rsp_rd, mon_e.rd);
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          // Success: one cycle after done. Timeout: WAIT lasts TIMEOUT cycles.
          if (prev_valid == '0)
            check("rsp_latency", 32'(cyc),
                  32'(mon_e.err ? start_cyc + TIMEOUT + 1 : done_cyc + 1));
          if ((rsp_valid & rsp_ready) != '0) begin
            void'(sb_q.pop_front());
            rsp_hs_cnt++;
          end
        end
      end

      if (prev_valid != '0 && !prev_hs) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'(prev_valid));
        check("rsp_hold_rd", rsp_rd, prev_rd);
      end

      prev_valid = rsp_valid;
      prev_rd    = rsp_rd;
      prev_hs    = ((rsp_valid & rsp_ready) != '0);
      prev_start = grev_start;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers used by the directed sequence.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic bit pending();
    bit p;
    p = (sb_q.size() != 0) || (req_valid != '0) || busy;
    for (int i = 0; i < NREQ; i++) if (rd_ptr[i] < stim_q[i].size()) p = 1;
    return p;
  endfunction

  task automatic wait_drain(input string tag, input int budget, input bit rand_lat);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      if (rand_lat) unit_lat = int'($urandom_range(1, 8));
      step();
      n++;
    end
    check({tag, "_drain"}, 32'(n < budget), 32'h1);
  endtask

  // Returns on the falling edge where rsp_valid[i] is first seen.
  task automatic wait_rsp(input string tag, input int i, input int budget);
    int n;
    n = 0;
    @(negedge clock);
    while (!rsp_valid[i] && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_rsp_wait"}, 32'(n < budget), 32'h1);
  endtask

  // Called in the first FLUSH cycle; leaves the bench just after the IDLE cycle.
  task automatic flush_check(input string tag);
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clock);
      check({tag, "_busy"}, 32'(busy), 32'h1);
      check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      step();
    end
    @(negedge clock);
    check({tag, "_idle"}, 32'(busy), 32'h0);
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence.
  // ---------------------------------------------------------------------------
  initial begin
    int         base;
    int         n;
    int         hs_base;
    logic [7:0] exp_order[4];

    resetn = 1'b0;

    // Contention: both requesters valid from reset exit.
    stim_q[0].push_back('{32'hDEAD_BEEF, 5'h03});
    stim_q[0].push_back('{32'h00FF_1234, 5'h10});
    stim_q[1].push_back('{32'hCAFE_F00D, 5'h08});
    stim_q[1].push_back('{32'h8000_0001, 5'h15});
    repeat (3) step();

    // Reset state, with requests already valid.
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_grev_start", 32'(grev_start), 32'h0);
    check("rst_grev_rs1", grev_rs1, 32'h0);
    check("rst_grev_rs2", 32'(grev_rs2), 32'h0);
    check("rst_rsp_rd", rsp_rd, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);

    resetn = 1'b1;
    flush_check("post_reset_flush");
    wait_drain("contention", 400, 0);
    exp_order = '{8'd0, 8'd1, 8'd0, 8'd1};
    check("contention_grants", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() >= 4)
      for (int k = 0; k < 4; k++) check("contention_order", 32'(grant_log[k]), 32'(exp_order[k]));

    // Single request from requester 0.
    unit_lat = 5;
    stim_q[0].push_back('{32'h1234_5678, 5'h1f});
    wait_rsp("single", 0, 100);
    check("single_rd", rsp_rd, 32'h1E6A_2C48);
    check("single_err", 32'(rsp_err), 32'h0);
    check("single_valid", 32'(rsp_valid), 32'h1);
    wait_drain("single", 100, 0);

    // Backpressure on requester 1 while requester 0 waits.
    base    = grant_log.size();
    hold[1] = 1;
    stim_q[1].push_back('{32'h0F0F_A5C3, 5'h0b});
    n = 0;
    while (grant_log.size() == base && n < 50) begin
      step();
      n++;
    end
    check("bp_first_grant", 32'(n < 50), 32'h1);
    stim_q[0].push_back('{32'h7654_3210, 5'h06});
    wait_rsp("bp", 1, 100);
    for (int k = 0; k < 20; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'h2);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_no_new_grant", 32'(grant_log.size()), 32'(base + 1));
      step();
      @(negedge clock);
    end
    hold[1] = 0;
    wait_drain("bp", 200, 0);
    check("bp_grants", 32'(grant_log.size()), 32'(base + 2));
    if (grant_log.size() >= base + 2) begin
      check("bp_order_a", 32'(grant_log[base]), 32'd1);
      check("bp_order_b", 32'(grant_log[base + 1]), 32'd0);
    end

    // Timeout: unit never answers; then a full flush before the next grant.
    unit_mute = 1;
    stim_q[0].push_back('{32'h1357_9BDF, 5'h11});
    n = 0;
    @(negedge clock);
    while (!(rsp_valid[0] && rsp_ready[0]) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("tmo_rsp_wait", 32'(n < 200), 32'h1);
    check("tmo_err", 32'(rsp_err), 32'h1);
    check("tmo_rd", rsp_rd, 32'h0);
    step();
    unit_mute = 0;
    stim_q[1].push_back('{32'h2468_ACE0, 5'h1c});
    flush_check("tmo_flush");
    wait_drain("tmo_next", 100, 0);

    // Reset during WAIT; the unit finishes 3 cycles after reset, inside FLUSH.
    unit_lat = 7;
    hs_base  = rsp_hs_cnt;
    stim_q[1].push_back('{32'hFEDC_BA98, 5'h09});
    n = 0;
    while (!grev_start && n < 50) begin
      step();
      n++;
    end
    check("midrst_start", 32'(n < 50), 32'h1);
    repeat (4) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    flush_check("midrst_flush");
    check("midrst_no_rsp", 32'(rsp_hs_cnt), 32'(hs_base));
    unit_lat = 3;
    stim_q[0].push_back('{32'h0000_FFFF, 5'h10});
    wait_drain("midrst_next", 100, 0);
    check("midrst_next_rsp", 32'(rsp_hs_cnt), 32'(hs_base + 1));

    // Random traffic: gaps, response stalls, random unit latency.
    rand_gaps  = 1;
    rand_stall = 1;
    hs_base    = rsp_hs_cnt;
    for (int k = 0; k < 400; k++) begin
      op_t op;
      op.rs1 = $urandom;
      op.rs2 = 5'($urandom);
      stim_q[$urandom_range(0, NREQ - 1)].push_back(op);
    end
    wait_drain("random", 30000, 1);
    check("random_count", 32'(rsp_hs_cnt), 32'(hs_base + 400));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
